// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor y = a - b with Y86 flags (ZF, SF, OF)
// and an unsigned borrow-out. Works DIGIT bits per clock, LSB first.
module serial_subtractor #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             bo
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
  logic             bo_q, bo_d;
  logic [DIGIT:0]   sum;
  logic             last_step;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    busy_d   = busy_q;
    done_d   = done_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    bo_d     = bo_q;

    sum       = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    last_step = (cnt_q == CW'(N - 1));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
          state_d  = BUSY;
          op_a_d   = a;
          op_b_d   = ~b;
          carry_d  = 1'b1;
          cnt_d    = '0;
          y_d      = '0;
          a_sign_d = a[WIDTH-1];
          b_sign_d = b[WIDTH-1];
          busy_d   = 1'b1;
          done_d   = 1'b0;
          zf_d     = 1'b0;
          sf_d     = 1'b0;
          of_d     = 1'b0;
          bo_d     = 1'b0;
        end
      end
      BUSY: begin
        y_d     = (y_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        op_a_d  = op_a_q >> DIGIT;
        op_b_d  = op_b_q >> DIGIT;
        carry_d = sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          zf_d    = (y_d == '0);
          sf_d    = y_d[WIDTH-1];
          of_d    = (a_sign_q != b_sign_q) && (y_d[WIDTH-1] != a_sign_q);
          bo_d    = ~sum[DIGIT];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state updates use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
      bo_q     <= bo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign zf   = zf_q;
  assign sf   = sf_q;
  assign of   = of_q;
  assign bo   = bo_q;

endmodule
